column_height_buffer: RTL and testbench
=======================================

// Module: column_height_buffer
// PURPOSE
//   Consumer end of the wall-height stream. Collects one wall_height per screen column, as
//   delivered by the height calculator's height/valid pulse, into a ping-pong column buffer.
//   Swaps front/back buffers at vblank once a full frame is written. Classifies each display
//   pixel (x,y) as ceiling / wall-X / wall-Y / floor for the pixel shader.
// PARAMETERS
//   NUM_COLS   640  screen columns = heights per frame
//   SCREEN_H   480  visible lines; heights clamp to this
//   COL_W      10   column index / pix_x width
//   HEIGHT_W   10   wall height / pix_y width
// PORTS
//   clk            in   1         system clock
//   rst_n          in   1         asynchronous active-low reset
//   wr_frame_start in   1         pulse: begin filling back buffer at column 0
//   height_in      in   HEIGHT_W  wall height for current column
//   side_in        in   1         0 = X-side hit, 1 = Y-side hit; stored with height
//   height_valid   in   1         1-cycle strobe; height_in/side_in valid
//   vblank_start   in   1         pulse at start of vertical blank
//   pix_x          in   COL_W     display column to classify
//   pix_y          in   HEIGHT_W  display line to classify
//   pix_valid      in   1         pix_x/pix_y valid this cycle
//   pix_class      out  2         0 ceiling, 1 wall X-side, 2 wall Y-side, 3 floor
//   pix_class_valid out 1         pix_class valid
//   fill_ready     out  1         write FSM in IDLE; next frame may start
//   buf_swapped    out  1         1-cycle pulse when front/back swap
//   overflow_err   out  1         sticky: a height_valid was dropped
// BEHAVIOUR
//   Reset (async, rst_n=0): write FSM->IDLE, wr_col=0, front_sel=0, front_valid=0,
//     pix_class=0, pix_class_valid=0, buf_swapped=0, overflow_err=0, fill_ready=1.
//   Storage: two NUM_COLS x (HEIGHT_W+1) arrays {side,height}. Contents not reset.
//   Write FSM:
//     IDLE: wr_frame_start -> FILL, wr_col=0. height_valid dropped, sets overflow_err.
//     FILL: height_valid writes back[wr_col], wr_col++.
//       The write to column NUM_COLS-1 -> FULL.
//       wr_frame_start in FILL aborts: wr_col=0, stays in FILL.
//       wr_frame_start and height_valid in the same cycle: write goes to column 0, wr_col=1.
//     FULL: height_valid dropped, sets overflow_err. vblank_start performs the swap:
//       front_sel toggles, front_valid=1, buf_swapped pulses the next cycle, -> IDLE.
//     vblank_start outside FULL: ignored; the front buffer keeps displaying.
//     Last write and vblank_start in the same cycle: the swap waits for the next vblank_start.
//   Read pipeline, latency 2, fully pipelined at 1 pixel per clock:
//     c0: registered read of front[pix_x].
//     c1: h_c = min(height, SCREEN_H); top = (SCREEN_H - h_c) >> 1; bot = top + h_c.
//     c1 output: y < top -> 0; y >= bot -> 3; otherwise 1 + side.
//     pix_class_valid = pix_valid delayed 2 cycles.
//     front_valid=0: height treated as 0, so y < SCREEN_H/2 -> 0, else 3.
//     pix_x >= NUM_COLS or pix_y >= SCREEN_H: class 0, valid still follows pix_valid.
//   Reads always use front, writes always use back; same-cycle access never collides.
//   A swap mid-line takes effect for pixels presented from the cycle after the swap.
//   Reset mid-fill discards the partial frame; display falls back to the empty view.
// TESTING
//   1. Reset, then pix (0,0) and (0,479) -> class 0 and class 3 respectively, valid 2 cycles later.
//   2. Fill 640 heights = 240, side 0; vblank -> buf_swapped pulse.
//      Then y=119 -> 0, y=120 -> 1, y=359 -> 1, y=360 -> 3.
//   3. Height 1000 at col 5 with side 1 -> clamps to 480: every y in 0..479 at x=5 -> class 2.
//   4. Write 641 heights -> the 641st is dropped, overflow_err=1 and stays set.
//      Write 639 then vblank -> no swap, old frame still shown.
//   5. wr_frame_start after 100 writes -> restart at column 0.
//      640 more writes then vblank -> swap; col 0 holds the post-restart value.
//   6. Last write and vblank in the same cycle -> no swap; next vblank swaps.
//      rst_n low mid-FILL -> IDLE, fill_ready=1, empty view shown.

Source files
------------

// File: rtl/column_height_buffer.sv
// -----------------------------------------------------------------------------
// column_height_buffer
//   Receiving end of the wall-height stream. One {side,height} entry per screen
//   column is written into the back half of a ping-pong buffer. When a full
//   frame has been written, the next vblank_start swaps front and back. Every
//   display pixel (x,y) is classified from the front half as ceiling, wall
//   X-side, wall Y-side or floor, with a 2-cycle, 1-pixel-per-clock pipeline.
//
// Ports
//   clk               system clock
//   rst_n             asynchronous active-low reset
//   i_wr_frame_start  pulse: start (or restart) filling the back buffer at col 0
//   i_height_in       wall height of the current column
//   i_side_in         0 = X-side hit, 1 = Y-side hit
//   i_height_valid    1-cycle strobe qualifying i_height_in / i_side_in
//   i_vblank_start    pulse at start of vertical blank (swap opportunity)
//   i_pix_x, i_pix_y  display pixel to classify
//   i_pix_valid       i_pix_x / i_pix_y valid this cycle
//   o_pix_class       0 ceiling, 1 wall X-side, 2 wall Y-side, 3 floor
//   o_pix_class_valid i_pix_valid delayed by 2 cycles
//   o_fill_ready      write side idle, a new frame may be started
//   o_buf_swapped     1-cycle pulse after front/back swap
//   o_overflow_err    sticky: a height strobe arrived when it could not be stored
// -----------------------------------------------------------------------------
module column_height_buffer #(
    parameter int NUM_COLS = 640,
    parameter int SCREEN_H = 480,
    parameter int COL_W    = 10,
    parameter int HEIGHT_W = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_wr_frame_start,
    input  logic [HEIGHT_W-1:0] i_height_in,
    input  logic                i_side_in,
    input  logic                i_height_valid,
    input  logic                i_vblank_start,
    input  logic [COL_W-1:0]    i_pix_x,
    input  logic [HEIGHT_W-1:0] i_pix_y,
    input  logic                i_pix_valid,
    output logic [1:0]          o_pix_class,
    output logic                o_pix_class_valid,
    output logic                o_fill_ready,
    output logic                o_buf_swapped,
    output logic                o_overflow_err
);

    localparam int ENTRY_W = HEIGHT_W + 1;
    localparam logic [COL_W-1:0]  LAST_COL   = COL_W'(NUM_COLS - 1);
    localparam logic [COL_W:0]    NUM_COLS_X = (COL_W + 1)'(NUM_COLS);
    localparam logic [HEIGHT_W:0] SCREEN_H_X = (HEIGHT_W + 1)'(SCREEN_H);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_FULL
    } wr_state_t;

    wr_state_t          r_state;
    wr_state_t          w_state_next;
    logic [COL_W-1:0]   r_wr_col;
    logic [COL_W-1:0]   w_wr_col_next;
    logic [COL_W-1:0]   w_wr_addr;
    logic               w_wr_en;
    logic               w_swap;
    logic               w_drop;
    logic               r_front_sel;
    logic               r_front_valid;
    logic               r_buf_swapped;
    logic               r_overflow_err;

    // ---------------- write FSM ----------------
    always_comb begin
        w_state_next  = r_state;
        w_wr_col_next = r_wr_col;
        w_wr_addr     = r_wr_col;
        w_wr_en       = 1'b0;
        w_swap        = 1'b0;
        w_drop        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_drop = i_height_valid;
                if (i_wr_frame_start) begin
                    w_state_next  = ST_FILL;
                    w_wr_col_next = '0;
                end
            end
            ST_FILL: begin
                if (i_wr_frame_start) begin
                    // Restart; a coincident strobe becomes the new column 0.
                    w_wr_addr     = '0;
                    w_wr_en       = i_height_valid;
                    w_wr_col_next = i_height_valid ? COL_W'(1) : '0;
                end else if (i_height_valid) begin
                    w_wr_en = 1'b1;
                    if (r_wr_col == LAST_COL) begin
                        w_state_next  = ST_FULL;
                        w_wr_col_next = '0;
                    end else begin
                        w_wr_col_next = r_wr_col + COL_W'(1);
                    end
                end
            end
            ST_FULL: begin
                w_drop = i_height_valid;
                if (i_vblank_start) begin
                    w_swap       = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_wr_col       <= '0;
            r_front_sel    <= 1'b0;
            r_front_valid  <= 1'b0;
            r_buf_swapped  <= 1'b0;
            r_overflow_err <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_wr_col       <= w_wr_col_next;
            r_front_sel    <= r_front_sel ^ w_swap;
            r_front_valid  <= r_front_valid | w_swap;
            r_buf_swapped  <= w_swap;
            r_overflow_err <= r_overflow_err | w_drop;
        end
    end

    // ---------------- ping-pong storage ----------------
    logic [ENTRY_W-1:0]        w_wr_data;
    logic [COL_W-1:0]          w_rd_addr;
    logic                      w_x_in_range;
    logic                      w_y_in_range;
    logic [1:0][ENTRY_W-1:0]   w_bank_rd;

    assign w_wr_data    = {i_side_in, i_height_in};
    assign w_x_in_range = ({1'b0, i_pix_x} < NUM_COLS_X);
    assign w_y_in_range = ({1'b0, i_pix_y} < SCREEN_H_X);
    // Out-of-range columns are forced to class 0 later; keep the address legal.
    assign w_rd_addr    = w_x_in_range ? i_pix_x : '0;

    // Both banks read every cycle; the bank not currently in front takes writes.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : gen_bank
            logic [ENTRY_W-1:0] r_mem [NUM_COLS];
            logic [ENTRY_W-1:0] r_rd;
            always_ff @(posedge clk) begin
                if (w_wr_en && (r_front_sel != 1'(gi))) begin
                    r_mem[w_wr_addr] <= w_wr_data;
                end
                r_rd <= r_mem[w_rd_addr];
            end
            assign w_bank_rd[gi] = r_rd;
        end
    endgenerate

    // ---------------- read pipeline ----------------
    // Stage c0 captures the pixel context alongside the RAM read, including
    // which bank was in front, so a swap only affects later pixels.
    logic                r_c0_valid;
    logic                r_c0_oob;
    logic [HEIGHT_W-1:0] r_c0_y;
    logic                r_c0_sel;
    logic                r_c0_fvalid;
    logic [1:0]          r_pix_class;
    logic                r_pix_class_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_c0_valid  <= 1'b0;
            r_c0_oob    <= 1'b0;
            r_c0_y      <= '0;
            r_c0_sel    <= 1'b0;
            r_c0_fvalid <= 1'b0;
        end else begin
            r_c0_valid  <= i_pix_valid;
            r_c0_oob    <= ~(w_x_in_range & w_y_in_range);
            r_c0_y      <= i_pix_y;
            r_c0_sel    <= r_front_sel;
            r_c0_fvalid <= r_front_valid;
        end
    end

    logic [ENTRY_W-1:0]  w_entry;
    logic [HEIGHT_W:0]   w_height;
    logic [HEIGHT_W:0]   w_h_clamp;
    logic [HEIGHT_W:0]   w_top;
    logic [HEIGHT_W:0]   w_bot;
    logic [HEIGHT_W:0]   w_y;
    logic [1:0]          w_class;

    assign w_entry   = w_bank_rd[r_c0_sel];
    // No frame shown yet: a zero height puts the horizon at mid-screen.
    assign w_height  = r_c0_fvalid ? {1'b0, w_entry[HEIGHT_W-1:0]} : '0;
    assign w_h_clamp = (w_height > SCREEN_H_X) ? SCREEN_H_X : w_height;
    assign w_top     = (SCREEN_H_X - w_h_clamp) >> 1;
    assign w_bot     = w_top + w_h_clamp;
    assign w_y       = {1'b0, r_c0_y};

    always_comb begin
        w_class = 2'd0;
        if (r_c0_oob || (w_y < w_top)) begin
            w_class = 2'd0;
        end else if (w_y >= w_bot) begin
            w_class = 2'd3;
        end else begin
            w_class = w_entry[HEIGHT_W] ? 2'd2 : 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pix_class       <= 2'd0;
            r_pix_class_valid <= 1'b0;
        end else begin
            r_pix_class       <= w_class;
            r_pix_class_valid <= r_c0_valid;
        end
    end

    assign o_pix_class       = r_pix_class;
    assign o_pix_class_valid = r_pix_class_valid;
    assign o_fill_ready      = (r_state == ST_IDLE);
    assign o_buf_swapped     = r_buf_swapped;
    assign o_overflow_err    = r_overflow_err;

endmodule

// File: tb/tb_column_height_buffer.sv
// -----------------------------------------------------------------------------
// tb_column_height_buffer
//   Self-checking bench for column_height_buffer. A frame-level reference model
//   (queue of pending heights, array of displayed heights) predicts the pixel
//   classes, swap pulses and overflow flag.
// -----------------------------------------------------------------------------
module tb_column_height_buffer;

    localparam int NC = 640;
    localparam int SH = 480;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wfs = 1'b0;
    logic       hv = 1'b0;
    logic       side = 1'b0;
    logic       vb = 1'b0;
    logic       pv = 1'b0;
    logic [9:0] hin = '0;
    logic [9:0] px = '0;
    logic [9:0] py = '0;
    logic [1:0] cls;
    logic       cls_v;
    logic       fill_ready;
    logic       swapped;
    logic       ovf;

    always #5 clk = ~clk;

    column_height_buffer #(
        .NUM_COLS(NC), .SCREEN_H(SH), .COL_W(10), .HEIGHT_W(10)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .i_wr_frame_start  (wfs),
        .i_height_in       (hin),
        .i_side_in         (side),
        .i_height_valid    (hv),
        .i_vblank_start    (vb),
        .i_pix_x           (px),
        .i_pix_y           (py),
        .i_pix_valid       (pv),
        .o_pix_class       (cls),
        .o_pix_class_valid (cls_v),
        .o_fill_ready      (fill_ready),
        .o_buf_swapped     (swapped),
        .o_overflow_err    (ovf)
    );

    int errors = 0;
    int checks = 0;

    // ---------------- reference model ----------------
    int  front_h [NC];
    bit  front_s [NC];
    bit  front_v = 0;
    bit  filling = 0;
    int  pend_h [$];
    bit  pend_s [$];
    bit  m_ovf = 0;
    bit  m_swap = 0;
    bit  st1_v = 0;
    int  st1_cls = 0;
    bit  out_v = 0;
    int  out_cls = 0;

    function automatic int classify(int x, int y);
        int h, top, bot;
        if (x >= NC || y >= SH) return 0;
        h = front_v ? front_h[x] : 0;
        if (h > SH) h = SH;
        top = (SH - h) / 2;
        bot = top + h;
        if (y < top) return 0;
        if (y >= bot) return 3;
        return 1 + int'(front_s[x]);
    endfunction

    function automatic bit frame_full();
        return filling && (pend_h.size() == NC);
    endfunction

    // Drive one clock of inputs (called at a negedge), advance the model over
    // the intervening posedge, and return at the next negedge with inputs idle.
    task automatic step(input bit f, input bit v, input int h, input bit s,
                        input bit b, input bit p, input int x, input int y);
        int e;
        wfs = f; hv = v; hin = 10'(h); side = s; vb = b;
        pv = p; px = 10'(x); py = 10'(y);
        e = classify(x, y);
        @(negedge clk);
        m_swap = 0;
        if (frame_full()) begin
            if (v) m_ovf = 1;
            if (b) begin
                for (int i = 0; i < NC; i++) begin
                    front_h[i] = pend_h[i];
                    front_s[i] = pend_s[i];
                end
                front_v = 1;
                filling = 0;
                pend_h.delete();
                pend_s.delete();
                m_swap = 1;
            end
        end else if (filling) begin
            if (f) begin
                pend_h.delete();
                pend_s.delete();
            end
            if (v) begin
                pend_h.push_back(h);
                pend_s.push_back(s);
            end
        end else begin
            if (v) m_ovf = 1;
            if (f) begin
                filling = 1;
                pend_h.delete();
                pend_s.delete();
            end
        end
        out_v   = st1_v;
        out_cls = st1_cls;
        st1_v   = p;
        st1_cls = e;
        wfs = 0; hv = 0; vb = 0; pv = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic model_reset();
        filling = 0;
        pend_h.delete();
        pend_s.delete();
        front_v = 0;
        m_ovf = 0;
        m_swap = 0;
        st1_v = 0; st1_cls = 0;
        out_v = 0; out_cls = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Write n random heights back to back (no pixels).
    task automatic write_random(input int n);
        for (int i = 0; i < n; i++)
            step(0, 1, $urandom_range(0, 1023), 1'($urandom_range(0, 1)), 0, 0, 0, 0);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        checks++;
        if ({fill_ready, ovf, cls_v, cls, swapped} !== 6'b100000)
            $display("FAIL reset_state: got %b expected 100000",
                     {fill_ready, ovf, cls_v, cls, swapped});
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 0, 0, 0, 0, 1, 0, 0);
        checks++;
        if (cls_v !== 1'b0) begin
            errors++;
            $display("FAIL reset_latency1: valid got %b expected 0", cls_v);
        end
        idle(1);
        checks++;
        if (cls_v !== 1'b1 || cls !== 2'd0 || out_cls != 0) begin
            errors++;
            $display("FAIL reset_pix_0_0: valid %b class %0d expected valid 1 class 0", cls_v, cls);
        end
        step(0, 0, 0, 0, 0, 1, 0, 479);
        idle(1);
        checks++;
        if (cls_v !== 1'b1 || cls !== 2'd3 || out_cls != 3) begin
            errors++;
            $display("FAIL reset_pix_0_479: valid %b class %0d expected valid 1 class 3", cls_v, cls);
        end
    endtask

    task automatic test_fill_swap();
        int ys [4] = '{119, 120, 359, 360};
        int ex [4] = '{0, 1, 1, 3};
        step(1, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (fill_ready !== 1'b0) begin
            errors++;
            $display("FAIL fill_ready_in_fill: got %b expected 0", fill_ready);
        end
        for (int i = 0; i < NC; i++) step(0, 1, 240, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0, 0);
        checks++;
        if (swapped !== 1'b1 || m_swap !== 1'b1) begin
            errors++;
            $display("FAIL swap_pulse: got %b expected 1", swapped);
        end
        idle(1);
        checks++;
        if (swapped !== 1'b0 || fill_ready !== 1'b1) begin
            errors++;
            $display("FAIL swap_pulse_end: swapped %b fill_ready %b expected 0 1", swapped, fill_ready);
        end
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 0, 0, 0, 1, 37, ys[k]);
            idle(1);
            checks++;
            if (cls_v !== 1'b1 || cls !== 2'(ex[k])) begin
                errors++;
                $display("FAIL h240_y%0d: valid %b class %0d expected class %0d", ys[k], cls_v, cls, ex[k]);
            end
        end
    endtask

    task automatic test_clamp();
        step(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < NC; i++) begin
            if (i == 5) step(0, 1, 1000, 1, 0, 0, 0, 0);
            else        step(0, 1, $urandom_range(0, 600), 1'($urandom_range(0, 1)), 0, 0, 0, 0);
        end
        step(0, 0, 0, 0, 1, 0, 0, 0);
        for (int y = 0; y <= SH; y++) begin
            step(0, 0, 0, 0, 0, (y < SH), 5, (y < SH) ? y : 0);
            if (y >= 1) begin
                checks++;
                if (cls_v !== 1'b1 || cls !== 2'd2) begin
                    errors++;
                    $display("FAIL clamp_x5_y%0d: valid %b class %0d expected class 2", y - 1, cls_v, cls);
                end
            end
        end
    endtask

    task automatic test_overflow();
        do_reset();
        step(0, 1, 77, 0, 0, 0, 0, 0);
        checks++;
        if (ovf !== 1'b1 || m_ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_idle: got %b expected 1", ovf);
        end
        do_reset();
        step(1, 0, 0, 0, 0, 0, 0, 0);
        write_random(NC);
        checks++;
        if (ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_after_640: got %b expected 0", ovf);
        end
        step(0, 1, 5, 0, 0, 0, 0, 0);
        checks++;
        if (ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_after_641: got %b expected 1", ovf);
        end
        step(0, 0, 0, 0, 1, 0, 0, 0);
        checks++;
        if (swapped !== 1'b1) begin
            errors++;
            $display("FAIL ovf_frame_swap: got %b expected 1", swapped);
        end
        step(1, 0, 0, 0, 0, 0, 0, 0);
        write_random(NC - 1);
        step(0, 0, 0, 0, 1, 0, 0, 0);
        checks++;
        if (swapped !== 1'b0 || ovf !== 1'b1 || fill_ready !== 1'b0) begin
            errors++;
            $display("FAIL partial_no_swap: swapped %b ovf %b fill_ready %b expected 0 1 0",
                     swapped, ovf, fill_ready);
        end
        for (int k = 0; k < 20; k++) begin
            step(0, 0, 0, 0, 0, 1, $urandom_range(0, NC - 1), $urandom_range(0, SH - 1));
            idle(1);
            checks++;
            if (cls_v !== 1'b1 || cls !== 2'(out_cls)) begin
                errors++;
                $display("FAIL old_frame_pix%0d: class %0d expected %0d", k, cls, out_cls);
            end
        end
    endtask

    task automatic test_restart();
        int ys [4] = '{89, 90, 389, 390};
        int ex [4] = '{0, 2, 2, 3};
        // Still in FILL from the partial frame: restart aborts it.
        step(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 100; i++) step(0, 1, 50, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 50; i++) step(0, 1, 50, 0, 0, 0, 0, 0);
        // Restart and first write in the same cycle.
        step(1, 1, 300, 1, 0, 0, 0, 0);
        write_random(NC - 1);
        step(0, 0, 0, 0, 1, 0, 0, 0);
        checks++;
        if (swapped !== 1'b1) begin
            errors++;
            $display("FAIL restart_swap: got %b expected 1", swapped);
        end
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 0, 0, 0, 1, 0, ys[k]);
            idle(1);
            checks++;
            if (cls_v !== 1'b1 || cls !== 2'(ex[k])) begin
                errors++;
                $display("FAIL restart_col0_y%0d: class %0d expected %0d", ys[k], cls, ex[k]);
            end
        end
    endtask

    task automatic test_last_write_vblank();
        step(1, 0, 0, 0, 0, 0, 0, 0);
        write_random(NC - 1);
        step(0, 1, 123, 0, 1, 0, 0, 0);
        checks++;
        if (swapped !== 1'b0) begin
            errors++;
            $display("FAIL last_write_vblank_noswap: got %b expected 0", swapped);
        end
        step(0, 0, 0, 0, 0, 1, NC - 1, $urandom_range(0, SH - 1));
        idle(1);
        checks++;
        if (cls !== 2'(out_cls) || swapped !== 1'b0) begin
            errors++;
            $display("FAIL last_write_old_view: class %0d expected %0d", cls, out_cls);
        end
        step(0, 0, 0, 0, 1, 0, 0, 0);
        checks++;
        if (swapped !== 1'b1) begin
            errors++;
            $display("FAIL last_write_next_vblank: got %b expected 1", swapped);
        end
        step(0, 0, 0, 0, 0, 1, NC - 1, 200);
        idle(1);
        checks++;
        if (cls !== 2'(out_cls)) begin
            errors++;
            $display("FAIL last_write_new_view: class %0d expected %0d", cls, out_cls);
        end
    endtask

    task automatic test_reset_midfill();
        step(1, 0, 0, 0, 0, 0, 0, 0);
        write_random(200);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (fill_ready !== 1'b1 || cls_v !== 1'b0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_midfill: fill_ready %b valid %b ovf %b expected 1 0 0",
                     fill_ready, cls_v, ovf);
        end
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 0, 0, 0, 0, 1, 10, 100);
        idle(1);
        checks++;
        if (cls !== 2'd0) begin
            errors++;
            $display("FAIL empty_view_y100: class %0d expected 0", cls);
        end
        step(0, 0, 0, 0, 0, 1, 10, 300);
        idle(1);
        checks++;
        if (cls !== 2'd3) begin
            errors++;
            $display("FAIL empty_view_y300: class %0d expected 3", cls);
        end
    endtask

    // Fill with gappy writes while a random pixel stream runs, then swap in the
    // middle of the stream; every cycle's output is scored against the model.
    task automatic test_back_to_back();
        int guard = 0;
        int n = 0;
        step(1, 0, 0, 0, 0, 0, 0, 0);
        while (!frame_full() && guard < 4000) begin
            step(0, 1'($urandom_range(0, 1)), $urandom_range(0, 1023), 1'($urandom_range(0, 1)),
                 0, 1'($urandom_range(0, 3) != 0), $urandom_range(0, 700), $urandom_range(0, 520));
            guard++;
            checks++;
            if (cls_v !== out_v || (out_v && cls !== 2'(out_cls))) begin
                errors++;
                $display("FAIL stream_fill_c%0d: valid %b class %0d expected valid %b class %0d",
                         guard, cls_v, cls, out_v, out_cls);
            end
        end
        checks++;
        if (!frame_full()) begin
            errors++;
            $display("FAIL stream_fill_bound: frame not complete after %0d cycles", guard);
        end
        for (int c = 0; c < 300; c++) begin
            step(0, 0, 0, 0, (c == 150), 1, $urandom_range(0, 700), $urandom_range(0, 520));
            checks++;
            if (cls_v !== out_v || (out_v && cls !== 2'(out_cls)) || swapped !== m_swap) begin
                errors++;
                $display("FAIL stream_c%0d: valid %b class %0d swap %b expected valid %b class %0d swap %b",
                         c, cls_v, cls, swapped, out_v, out_cls, m_swap);
            end
            if (m_swap) n++;
        end
        checks++;
        if (n != 1) begin
            errors++;
            $display("FAIL stream_swap_count: got %0d expected 1", n);
        end
    endtask

    initial begin
        test_reset();
        test_fill_swap();
        test_clamp();
        test_overflow();
        test_restart();
        test_last_write_vblank();
        test_reset_midfill();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
